// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: the instruction word type,
// the NOP encoding and the default parameter values.
package fetch_stage_pkg;

    typedef logic [31:0] instr_t;

    localparam instr_t      NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_BYTES = 512;

endpackage

// File: rtl/fetch_stage_addr_check.sv
// Combinational fetch-address legality check: the address must be word aligned
// and must leave room for a whole word inside the instruction memory.
module fetch_addr_check
    import fetch_stage_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input  logic [31:0] addr_i,
    output logic        legal_o
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

    always_comb begin
        legal_o = (addr_i[1:0] == 2'b00) && (addr_i <= LAST_ADDR);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and captures the returned word into the IF/ID register toward decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    instr_t      instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        fault_q, fault_d;
    logic [31:0] faultpc_q, faultpc_d;
    logic [31:0] count_q, count_d;

    logic        pc_legal;
    logic        target_legal;
    logic        advance;

    fetch_addr_check #(.IMEM_BYTES(IMEM_BYTES)) u_pc_check (
        .addr_i  (pc_q),
        .legal_o (pc_legal)
    );

    fetch_addr_check #(.IMEM_BYTES(IMEM_BYTES)) u_target_check (
        .addr_i  (redirect_target),
        .legal_o (target_legal)
    );

    always_comb begin
        advance   = !fault_q && (!valid_q || id_ready);

        pc_d      = pc_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        ifpc_d    = ifpc_q;
        ifpc4_d   = ifpc4_q;
        fault_d   = fault_q;
        faultpc_d = faultpc_q;
        count_d   = count_q;

        if (fault_q) begin
            // Frozen except for handing off an entry decode is still waiting on.
            if (valid_q && id_ready) begin
                valid_d = 1'b0;
            end
        end else if (redirect_valid) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = redirect_target;
            if (!target_legal) begin
                fault_d   = 1'b1;
                faultpc_d = redirect_target;
            end
        end else if (advance) begin
            if (pc_legal) begin
                instr_d = imem_data;
                ifpc_d  = pc_q;
                ifpc4_d = pc_q + 32'd4;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
                count_d = count_q + 32'd1;
            end else begin
                // No new word; an entry decode accepted this edge is consumed.
                fault_d   = 1'b1;
                faultpc_d = pc_q;
                valid_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            ifpc_q    <= '0;
            ifpc4_q   <= '0;
            fault_q   <= 1'b0;
            faultpc_q <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            ifpc_q    <= ifpc_d;
            ifpc4_q   <= ifpc4_d;
            fault_q   <= fault_d;
            faultpc_q <= faultpc_d;
            count_q   <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign if_pc_plus4 = ifpc4_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = faultpc_q;
    assign fetch_count = count_q;

endmodule
